// File: rtl/coherence_bus_ctrl.sv
// Two-core snooping bus controller: arbitrates I-fetch, D-load and write-back onto one RAM port.
// Words complete only on ramstate==ACCESS; waits/data are combinational from state and ports.
module coherence_bus_ctrl #(
    parameter int CPUS = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS-1:0][31:0]  iaddr,
    output logic [CPUS-1:0][31:0]  iload,
    output logic [CPUS-1:0]        iwait,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS-1:0][31:0]  daddr,
    input  logic [CPUS-1:0][31:0]  dstore,
    output logic [CPUS-1:0][31:0]  dload,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS-1:0]        ccwait,
    output logic [CPUS-1:0]        ccinv,
    output logic [CPUS-1:0][31:0]  ccsnoopaddr,
    input  logic [CPUS-1:0]        ccwrite,
    input  logic [CPUS-1:0]        cctrans,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [31:0]            ramaddr,
    output logic [31:0]            ramstore,
    input  logic [31:0]            ramload,
    input  logic [1:0]             ramstate
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [2:0] {
        IDLE, WB, SNOOP, LD1, LD2, C2C1, C2C2, INST
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   rr_q, rr_d;
    logic   irr_q, irr_d;

    logic   k, j, win, access;
    logic [CPUS-1:0] dreq;

    // Invalidations bypass the FSM so a write hit is never delayed by a snoop.
    assign ccinv[0]       = cctrans[1];
    assign ccinv[1]       = cctrans[0];
    assign ccsnoopaddr[0] = daddr[1];
    assign ccsnoopaddr[1] = daddr[0];
    assign iload[0]       = ramload;
    assign iload[1]       = ramload;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
            irr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            irr_q   <= irr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        irr_d    = irr_q;
        win      = 1'b0;
        iwait    = '1;
        dwait    = '1;
        ccwait   = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        dload[0] = ramload;
        dload[1] = ramload;
        k        = grant_q;
        j        = ~grant_q;
        access   = (ramstate == RAM_ACCESS);
        dreq     = dREN | dWEN;

        unique case (state_q)
            IDLE: begin
                if (|dreq) begin
                    win     = (&dreq) ? ~rr_q : dreq[1];
                    grant_d = win;
                    rr_d    = win;
                    state_d = dWEN[win] ? WB : SNOOP;
                end else if (|iREN) begin
                    win     = (&iREN) ? ~irr_q : iREN[1];
                    grant_d = win;
                    irr_d   = win;
                    state_d = INST;
                end
            end
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[k];
                ramstore = dstore[k];
                if (access) dwait[k] = 1'b0;
                // Eviction followed by a fill keeps the grant and goes straight to snoop.
                if (!dWEN[k]) state_d = dREN[k] ? SNOOP : IDLE;
            end
            SNOOP: begin
                ccwait[j] = 1'b1;
                state_d   = ccwrite[j] ? C2C1 : LD1;
            end
            LD1, LD2: begin
                ramREN  = 1'b1;
                ramaddr = daddr[k];
                if (access) begin
                    dwait[k] = 1'b0;
                    state_d  = (state_q == LD1) ? LD2 : IDLE;
                end
            end
            C2C1, C2C2: begin
                // Dirty data goes to the requester and to RAM in the same cycle.
                ccwait[j] = 1'b1;
                dload[k]  = dstore[j];
                ramWEN    = 1'b1;
                ramaddr   = daddr[k];
                ramstore  = dstore[j];
                if (access) begin
                    dwait[k] = 1'b0;
                    state_d  = (state_q == C2C1) ? C2C2 : IDLE;
                end
            end
            INST: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[k];
                if (access) begin
                    iwait[k] = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
